divisor_arbitro: RTL

Two-port round-robin arbiter and sequencer that shares one fully pipelined divider (Start/Num/Den in, Done/Coc/Res out, fixed latency) between two requesters. It accepts one division per cycle, tracks every in-flight operation in a tag pipeline, routes each result back to its requester, and flags divide-by-zero and divider/tag desynchronisation. It sits between the requesting blocks and the segmented divider; the divider shares CLK and RSTa with it.

---
 rtl/divisor_arbitro.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/divisor_arbitro.sv
// rtl/divisor_arbitro.sv - two-port round-robin arbiter/sequencer for a shared pipelined divider
//
// Purpose: grants one of two requesters per cycle, issues the granted division
// to a fixed-latency pipelined divider, tracks each in-flight operation in a
// tag pipeline and steers every result back to the port that asked for it.
//
// Ports:
//   CLK, RSTa                      clock, synchronous active-high reset
//   ReqN_Valid/Num/Den, ReqN_Ready request handshake per port (N = 0, 1)
//   RspN_Valid/Coc/Res/Div0        one-cycle result pulse per port, no backpressure
//   Div_Start/Num/Den              registered issue to the divider
//   Div_Done/Coc/Res               divider results, LAT cycles after Div_Start
//   Busy                           any operation issued or in flight
//   Sync_Err                       sticky: divider Done disagreed with the tag pipeline
module divisor_arbitro #(
  parameter int tamanyo = 32,
  parameter int LAT     = 16
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Req0_Valid,
  input  logic [tamanyo-1:0] Req0_Num,
  input  logic [tamanyo-1:0] Req0_Den,
  output logic               Req0_Ready,
  input  logic               Req1_Valid,
  input  logic [tamanyo-1:0] Req1_Num,
  input  logic [tamanyo-1:0] Req1_Den,
  output logic               Req1_Ready,
  output logic               Rsp0_Valid,
  output logic [tamanyo-1:0] Rsp0_Coc,
  output logic [tamanyo-1:0] Rsp0_Res,
  output logic               Rsp0_Div0,
  output logic               Rsp1_Valid,
  output logic [tamanyo-1:0] Rsp1_Coc,
  output logic [tamanyo-1:0] Rsp1_Res,
  output logic               Rsp1_Div0,
  output logic               Div_Start,
  output logic [tamanyo-1:0] Div_Num,
  output logic [tamanyo-1:0] Div_Den,
  input  logic               Div_Done,
  input  logic [tamanyo-1:0] Div_Coc,
  input  logic [tamanyo-1:0] Div_Res,
  output logic               Busy,
  output logic               Sync_Err
);

  // Arbitration state: id of the port granted on the last handshake.
  logic last_grant_q, last_grant_d;

  // Issue stage: operands plus the id/div0 tag that travels with them.
  logic               div_start_q, div_start_d;
  logic [tamanyo-1:0] div_num_q, div_num_d;
  logic [tamanyo-1:0] div_den_q, div_den_d;
  logic               iss_id_q, iss_id_d;
  logic               iss_z_q, iss_z_d;

  // Tag pipeline; bit LAT-1 is the head, lined up with the expected Div_Done.
  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;
  logic [LAT-1:0] tag_z_q, tag_z_d;

  // Response registers.
  logic               rsp0_valid_q, rsp0_valid_d;
  logic [tamanyo-1:0] rsp0_coc_q, rsp0_coc_d;
  logic [tamanyo-1:0] rsp0_res_q, rsp0_res_d;
  logic               rsp0_div0_q, rsp0_div0_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic [tamanyo-1:0] rsp1_coc_q, rsp1_coc_d;
  logic [tamanyo-1:0] rsp1_res_q, rsp1_res_d;
  logic               rsp1_div0_q, rsp1_div0_d;
  logic               sync_err_q, sync_err_d;

  logic               hs0, hs1, hs;
  logic [tamanyo-1:0] sel_num, sel_den;
  logic               head_v, head_id, head_z, ret;
  logic [tamanyo-1:0] ret_coc, ret_res;

  // Extended vectors let the shift work for any LAT >= 1 without slicing past bit 0.
  logic [LAT:0] tag_v_ext, tag_id_ext, tag_z_ext;

  // A lone requester always wins; on contention the port not granted last wins.
  assign Req0_Ready = Req0_Valid & (~Req1_Valid | last_grant_q);
  assign Req1_Ready = Req1_Valid & (~Req0_Valid | ~last_grant_q);

  assign hs0     = Req0_Valid & Req0_Ready;
  assign hs1     = Req1_Valid & Req1_Ready;
  assign hs      = hs0 | hs1;
  assign sel_num = hs1 ? Req1_Num : Req0_Num;
  assign sel_den = hs1 ? Req1_Den : Req0_Den;

  assign head_v  = tag_v_q[LAT-1];
  assign head_id = tag_id_q[LAT-1];
  assign head_z  = tag_z_q[LAT-1];
  assign ret     = head_v & Div_Done;
  // Divide-by-zero still goes through the divider; its result is replaced here.
  assign ret_coc = head_z ? {tamanyo{1'b1}} : Div_Coc;
  assign ret_res = head_z ? {tamanyo{1'b0}} : Div_Res;

  assign tag_v_ext  = {tag_v_q,  div_start_q};
  assign tag_id_ext = {tag_id_q, iss_id_q};
  assign tag_z_ext  = {tag_z_q,  iss_z_q};

  always_comb begin
    last_grant_d = hs ? hs1 : last_grant_q;

    div_start_d = hs;
    div_num_d   = hs ? sel_num : div_num_q;
    div_den_d   = hs ? sel_den : div_den_q;
    iss_id_d    = hs ? hs1 : iss_id_q;
    iss_z_d     = hs ? (sel_den == '0) : iss_z_q;

    tag_v_d  = tag_v_ext[LAT-1:0];
    tag_id_d = tag_id_ext[LAT-1:0];
    tag_z_d  = tag_z_ext[LAT-1:0];

    rsp0_valid_d = ret & ~head_id;
    rsp0_coc_d   = rsp0_coc_q;
    rsp0_res_d   = rsp0_res_q;
    rsp0_div0_d  = rsp0_div0_q;
    rsp1_valid_d = ret & head_id;
    rsp1_coc_d   = rsp1_coc_q;
    rsp1_res_d   = rsp1_res_q;
    rsp1_div0_d  = rsp1_div0_q;
    if (rsp0_valid_d) begin
      rsp0_coc_d  = ret_coc;
      rsp0_res_d  = ret_res;
      rsp0_div0_d = head_z;
    end
    if (rsp1_valid_d) begin
      rsp1_coc_d  = ret_coc;
      rsp1_res_d  = ret_res;
      rsp1_div0_d = head_z;
    end

    // A mismatched slot is simply dropped: it shifts out with no response.
    sync_err_d = sync_err_q | (Div_Done != head_v);
  end

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      last_grant_q <= 1'b1;
      div_start_q  <= 1'b0;
      div_num_q    <= '0;
      div_den_q    <= '0;
      iss_id_q     <= 1'b0;
      iss_z_q      <= 1'b0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      tag_z_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_coc_q   <= '0;
      rsp0_res_q   <= '0;
      rsp0_div0_q  <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_coc_q   <= '0;
      rsp1_res_q   <= '0;
      rsp1_div0_q  <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      div_start_q  <= div_start_d;
      div_num_q    <= div_num_d;
      div_den_q    <= div_den_d;
      iss_id_q     <= iss_id_d;
      iss_z_q      <= iss_z_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      tag_z_q      <= tag_z_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_coc_q   <= rsp0_coc_d;
      rsp0_res_q   <= rsp0_res_d;
      rsp0_div0_q  <= rsp0_div0_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_coc_q   <= rsp1_coc_d;
      rsp1_res_q   <= rsp1_res_d;
      rsp1_div0_q  <= rsp1_div0_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign Div_Start  = div_start_q;
  assign Div_Num    = div_num_q;
  assign Div_Den    = div_den_q;
  assign Rsp0_Valid = rsp0_valid_q;
  assign Rsp0_Coc   = rsp0_coc_q;
  assign Rsp0_Res   = rsp0_res_q;
  assign Rsp0_Div0  = rsp0_div0_q;
  assign Rsp1_Valid = rsp1_valid_q;
  assign Rsp1_Coc   = rsp1_coc_q;
  assign Rsp1_Res   = rsp1_res_q;
  assign Rsp1_Div0  = rsp1_div0_q;
  assign Busy       = div_start_q | (|tag_v_q);
  assign Sync_Err   = sync_err_q;

endmodule
